rg_trng_collector: RTL

//  Parametrised Galois-style ring generator with per-bit entropy injection, followed by a

---
 rtl/rg_trng_pkg.sv | 26 ++
 rtl/rg_galois_core.sv | 46 ++++
 rtl/rg_trng_collector.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rg_trng_pkg.sv
// Shared constants and helpers for the ring-generator TRNG collector.
// Holds default feedback/injection masks for the common ring widths and a
// popcount used to size and cross-check the entropy input.
package rg_trng_pkg;

  // Feedback taps (bit N-1 is implicit: it always receives state[0]).
  localparam logic [15:0] DEF_TAP_MASK_16 = 16'h3400;
  localparam logic [31:0] DEF_TAP_MASK_32 = 32'h0200_8080;
  localparam logic [63:0] DEF_TAP_MASK_64 = 64'h5800_0000_0000_0000;

  // Entropy injection positions (bit N-1 is never used for injection).
  localparam logic [15:0] DEF_ENT_MASK_16 = 16'h7DDB;
  localparam logic [31:0] DEF_ENT_MASK_32 = 32'h7DDB_7F7B;
  localparam logic [63:0] DEF_ENT_MASK_64 = 64'h7DDB_7F7B_7DDB_7F7B;

  // Number of set bits in a mask of up to 64 bits.
  function automatic int popcount(input logic [63:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/rg_galois_core.sv
// Galois-style ring generator state with per-bit entropy injection.
// The k-th set bit of ENT_MASK (counting from the LSB) is XORed with entropy[k].
module rg_galois_core
  import rg_trng_pkg::*;
#(
  parameter int             N        = 32,
  parameter logic [N-1:0]   TAP_MASK = N'(DEF_TAP_MASK_32),
  parameter logic [N-1:0]   ENT_MASK = N'(DEF_ENT_MASK_32),
  parameter int             ENT_W    = popcount(64'(ENT_MASK[N-2:0]))
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             step_en,
  input  logic [ENT_W-1:0] entropy,
  output logic [N-1:0]     state
);

  logic [N-2:0]     ent_pos;
  logic [ENT_W-1:0] ent_rest;
  logic [N-1:0]     next_state;

  // Scatter the packed entropy bits onto the ring positions selected by ENT_MASK.
  always_comb begin
    ent_pos  = '0;
    ent_rest = entropy;
    for (int i = 0; i < N - 1; i++) begin
      if (ENT_MASK[i]) begin
        ent_pos[i] = ent_rest[0];
        ent_rest   = ent_rest >> 1;
      end
    end
  end

  assign next_state = {state[0],
                       state[N-1:1] ^ (TAP_MASK[N-2:0] & {(N-1){state[0]}}) ^ ent_pos};

  // Advance the ring only on enabled cycles; otherwise hold.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= '0;
    end else if (step_en) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/rg_trng_collector.sv
// TRNG collector: ring generator followed by warm-up discard, serial-to-word
// packer, repetition-count health test and a one-word valid/ready register.
module rg_trng_collector
  import rg_trng_pkg::*;
#(
  parameter int           N         = 32,
  parameter logic [N-1:0] TAP_MASK  = N'(DEF_TAP_MASK_32),
  parameter logic [N-1:0] ENT_MASK  = N'(DEF_ENT_MASK_32),
  parameter int           ENT_W     = popcount(64'(ENT_MASK[N-2:0])),
  parameter int           OUT_W     = 8,
  parameter int           WARMUP    = 64,
  parameter int           REP_LIMIT = 31
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic [ENT_W-1:0] iEntropy,
  input  logic             iClrFlags,
  output logic [OUT_W-1:0] oData,
  output logic             oValid,
  input  logic             iReady,
  output logic             oSerial,
  output logic             oWarm,
  output logic             oFault,
  output logic             oOverrun
);

  localparam int WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int BCW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int RCW = $clog2(REP_LIMIT + 1);

  if (ENT_W != popcount(64'(ENT_MASK[N-2:0]))) begin : g_ent_w_check
    $error("ENT_W must equal the number of injection positions in ENT_MASK[N-2:0]");
  end
  if (N < 8 || OUT_W < 1 || OUT_W > 32 || REP_LIMIT < 1) begin : g_param_check
    $error("rg_trng_collector parameter out of range");
  end

  logic [N-1:0]     state;
  logic             serial_bit;
  logic             en_q;
  logic             en_fall;
  logic             warm;
  logic [WCW-1:0]   warm_cnt;
  logic [OUT_W-1:0] pack_sr;
  logic [OUT_W-1:0] pack_shift;
  logic [BCW-1:0]   bit_cnt;
  logic             collect;
  logic             word_done;
  logic             word_load;
  logic             overrun_set;
  logic [RCW-1:0]   rep_cnt;
  logic [RCW-1:0]   rep_next;
  logic             last_bit;
  logic             fault_set;

  rg_galois_core #(
    .N        (N),
    .TAP_MASK (TAP_MASK),
    .ENT_MASK (ENT_MASK),
    .ENT_W    (ENT_W)
  ) u_core (
    .iClk    (iClk),
    .iRst    (iRst),
    .step_en (iEn),
    .entropy (iEntropy),
    .state   (state)
  );

  assign serial_bit  = state[0];
  assign oSerial     = serial_bit;
  assign oWarm       = warm;
  assign en_fall     = en_q & ~iEn;
  assign collect     = iEn & warm;
  assign pack_shift  = (pack_sr << 1) | OUT_W'(serial_bit);
  assign word_done   = collect & (bit_cnt == BCW'(OUT_W - 1));
  assign word_load   = word_done & (~oValid | iReady);
  assign overrun_set = word_done & ~word_load;
  assign fault_set   = collect & (rep_next >= RCW'(REP_LIMIT));

  // Remember last cycle's enable so a 1->0 transition can restart warm-up.
  always_ff @(posedge iClk) begin
    if (iRst) en_q <= 1'b0;
    else      en_q <= iEn;
  end

  // Discard the first WARMUP ring steps after reset or after the enable drops.
  always_ff @(posedge iClk) begin
    if (iRst || en_fall) begin
      warm     <= (WARMUP == 0);
      warm_cnt <= '0;
    end else if (iEn && !warm) begin
      warm_cnt <= warm_cnt + WCW'(1);
      if (warm_cnt + WCW'(1) == WCW'(WARMUP)) warm <= 1'b1;
    end
  end

  // Shift post-warm-up serial bits into the packer; the first bit ends in the MSB.
  always_ff @(posedge iClk) begin
    if (iRst || en_fall) begin
      pack_sr <= '0;
      bit_cnt <= '0;
    end else if (collect) begin
      if (word_done) begin
        pack_sr <= '0;
        bit_cnt <= '0;
      end else begin
        pack_sr <= pack_shift;
        bit_cnt <= bit_cnt + BCW'(1);
      end
    end
  end

  // One-word output register: load a finished word if free or being drained.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oValid <= 1'b0;
      oData  <= '0;
    end else if (word_load) begin
      oValid <= 1'b1;
      oData  <= pack_shift;
    end else if (oValid && iReady) begin
      oValid <= 1'b0;
    end
  end

  // Run length of the current serial value, saturating at REP_LIMIT.
  always_comb begin
    rep_next = RCW'(1);
    if (rep_cnt != '0 && serial_bit == last_bit) begin
      if (rep_cnt == RCW'(REP_LIMIT)) rep_next = rep_cnt;
      else                            rep_next = rep_cnt + RCW'(1);
    end
  end

  // Track the repetition run on post-warm-up ring steps.
  always_ff @(posedge iClk) begin
    if (iRst || en_fall) begin
      rep_cnt  <= '0;
      last_bit <= 1'b0;
    end else if (collect) begin
      rep_cnt  <= rep_next;
      last_bit <= serial_bit;
    end
  end

  // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oFault   <= 1'b0;
      oOverrun <= 1'b0;
    end else begin
      oFault   <= fault_set   | (oFault   & ~iClrFlags);
      oOverrun <= overrun_set | (oOverrun & ~iClrFlags);
    end
  end

endmodule
